// File: rtl/seg_debug_pager_if.sv
// Bundles the debug-pager inputs and LED outputs. The producer of debug words
// (master) drives btn/mode/freeze/page_data; the pager (slave) drives led/page/frozen.
interface seg_debug_pager_if #(
  parameter int N_DIGITS = 8,
  parameter int N_PAGES  = 4
);
  localparam int PW = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;

  logic                          btn;
  logic                          mode_auto;
  logic                          freeze;
  logic [N_PAGES*4*N_DIGITS-1:0] page_data;
  logic [7*N_DIGITS-1:0]         led;
  logic [PW-1:0]                 page;
  logic                          frozen;

  modport master (
    output btn, mode_auto, freeze, page_data,
    input  led, page, frozen
  );

  modport slave (
    input  btn, mode_auto, freeze, page_data,
    output led, page, frozen
  );
endinterface

// File: rtl/seg_debug_pager.sv
// Pages one of N_PAGES debug words onto N_DIGITS seven-segment digits, advanced by a
// debounced button or an auto-cycle timer, with freeze and optional leading-zero blanking.
module seg_debug_pager #(
  parameter int N_DIGITS        = 8,
  parameter int N_PAGES         = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int AUTO_CYCLES     = 24000000,
  parameter int BLANK_LZ        = 0
) (
  input  logic              clk,
  input  logic              rst,
  seg_debug_pager_if.slave  bus
);
  localparam int PW     = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;
  localparam int WORD_W = 4 * N_DIGITS;
  localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW     = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(N_PAGES - 1);

  logic              r_sync1, r_sync2;
  logic              r_db;
  logic [DW-1:0]     r_db_cnt;
  logic              r_mode_prev;
  logic [AW-1:0]     r_auto_cnt;
  logic [PW-1:0]     r_page;
  logic [WORD_W-1:0] r_disp;
  logic              r_frozen;

  logic              w_adv_btn;
  logic              w_mode_rise;
  logic              w_auto_run;
  logic [AW-1:0]     w_auto_base;
  logic              w_adv_auto;
  logic              w_adv;
  logic [AW-1:0]     w_auto_nxt;
  logic [PW-1:0]     w_page_nxt;
  logic [WORD_W-1:0] w_word;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // The debounced level rises on the same edge that produces the advance pulse.
  assign w_adv_btn   = r_sync2 & ~r_db & (r_db_cnt == DB_MAX);
  assign w_mode_rise = bus.mode_auto & ~r_mode_prev;
  assign w_auto_run  = bus.mode_auto & ~bus.freeze;
  assign w_page_nxt  = (r_page == PAGE_MAX) ? '0 : r_page + PW'(1);

  // A 0->1 on mode_auto discards the held count; that cycle counts as tick 0.
  always_comb begin
    w_auto_base = w_mode_rise ? '0 : r_auto_cnt;
    w_adv_auto  = w_auto_run & (w_auto_base == AUTO_MAX);
    w_adv       = (w_adv_btn | w_adv_auto) & ~bus.freeze;
    w_auto_nxt  = w_auto_base;
    if (w_adv)           w_auto_nxt = '0;
    else if (w_auto_run) w_auto_nxt = w_auto_base + AW'(1);
  end

  always_comb begin
    w_word = '0;
    for (int p = 0; p < N_PAGES; p++) begin
      if (r_page == PW'(p)) w_word = bus.page_data[p*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_db        <= 1'b0;
      r_db_cnt    <= '0;
      r_mode_prev <= 1'b0;
      r_auto_cnt  <= '0;
      r_page      <= '0;
      r_disp      <= '0;
      r_frozen    <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DB_MAX) begin
          r_db     <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
      r_mode_prev <= bus.mode_auto;
      r_auto_cnt  <= w_auto_nxt;
      if (w_adv) r_page <= w_page_nxt;
      // Display samples the registered page, so a page change reaches led one edge later.
      if (!bus.freeze) r_disp <= w_word;
      r_frozen <= bus.freeze;
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic w_blank;
    assign w_blank = (BLANK_LZ != 0) && (gi > 0) && (r_disp[WORD_W-1:4*gi] == '0);
    assign bus.led[gi*7 +: 7] = w_blank ? 7'h00 : seg7(r_disp[gi*4 +: 4]);
  end

  assign bus.page   = r_page;
  assign bus.frozen = r_frozen;
endmodule

// File: tb/tb_seg_debug_pager.sv
// Directed bench for seg_debug_pager: a driver queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_seg_debug_pager;
  localparam int ND = 8;
  localparam int NP = 4;

  localparam logic [55:0] L_ZERO = {8{7'h3F}};
  localparam logic [55:0] L_P1   = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h77, 7'h71};
  localparam logic [55:0] L_P3   = {7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [55:0] L_DEAD = {7'h5E, 7'h79, 7'h77, 7'h5E, 7'h7C, 7'h79, 7'h79, 7'h71};
  localparam logic [55:0] L_300  = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h3F, 7'h3F};
  localparam logic [55:0] B_300  = {35'h0, 7'h4F, 7'h3F, 7'h3F};
  localparam logic [55:0] B_0    = {49'h0, 7'h3F};
  localparam logic [55:0] B_TOP  = {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  localparam int K_PAGE = 0;
  localparam int K_LED = 1;
  localparam int K_FRZ = 2;
  localparam int K_BLED = 3;

  logic clk = 1'b0;
  logic rst;

  seg_debug_pager_if #(.N_DIGITS(ND), .N_PAGES(NP)) bus ();
  seg_debug_pager_if #(.N_DIGITS(ND), .N_PAGES(NP)) bbus ();

  seg_debug_pager #(
    .N_DIGITS(ND), .N_PAGES(NP), .DEBOUNCE_CYCLES(4), .AUTO_CYCLES(10), .BLANK_LZ(0)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  seg_debug_pager #(
    .N_DIGITS(ND), .N_PAGES(NP), .DEBOUNCE_CYCLES(4), .AUTO_CYCLES(10), .BLANK_LZ(1)
  ) dut_blank (.clk(clk), .rst(rst), .bus(bbus.slave));

  always #5 clk = ~clk;

  logic [55:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          n_total = 0;
  int          n_bad = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input int kind, input logic [55:0] exp, input string name);
    kind_q.push_back(kind);
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic press_adv();
    bus.btn = 1'b1;
    cyc(8);
    bus.btn = 1'b0;
    cyc(8);
  endtask

  task automatic set_blank_word(input logic [31:0] w);
    bbus.page_data = {4{w}};
  endtask

  logic [55:0] mon_act;
  logic [55:0] mon_exp;
  int          mon_kind;
  string       mon_name;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_kind = kind_q.pop_front();
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      case (mon_kind)
        K_PAGE:  mon_act = 56'(bus.page);
        K_LED:   mon_act = bus.led;
        K_FRZ:   mon_act = 56'(bus.frozen);
        default: mon_act = bbus.led;
      endcase
      n_total++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.btn        = 1'b0;
    bus.mode_auto  = 1'b0;
    bus.freeze     = 1'b0;
    bus.page_data  = {32'h8765_4321, 32'h0000_0300, 32'h0000_12AF, 32'h0000_0000};
    bbus.btn       = 1'b0;
    bbus.mode_auto = 1'b0;
    bbus.freeze    = 1'b0;
    set_blank_word(32'h0000_0000);

    cyc(2);
    chk(K_PAGE, 56'd0, "rst_page");
    chk(K_LED, L_ZERO, "rst_led");
    chk(K_FRZ, 56'd0, "rst_frozen");
    chk(K_BLED, B_0, "rst_blank_led");
    rst = 1'b0;

    // Two-cycle glitch never survives the debouncer.
    bus.btn = 1'b1;
    cyc(2);
    bus.btn = 1'b0;
    cyc(6);
    chk(K_PAGE, 56'd0, "glitch_page");

    // Held press: 2 sync edges + 4 stable edges, page moves on the 6th edge.
    bus.btn = 1'b1;
    cyc(5);
    chk(K_PAGE, 56'd0, "press_before");
    cyc(1);
    chk(K_PAGE, 56'd1, "press_page");
    chk(K_LED, L_ZERO, "press_led_lag");
    cyc(1);
    chk(K_LED, L_P1, "press_led_p1");
    cyc(1);
    bus.btn = 1'b0;
    cyc(8);
    chk(K_PAGE, 56'd1, "press_once");

    press_adv();
    chk(K_PAGE, 56'd2, "page2");
    chk(K_LED, L_300, "led_p2");
    press_adv();
    chk(K_PAGE, 56'd3, "page3");
    chk(K_LED, L_P3, "led_p3");

    // Auto mode from page 3: wrap to 0 on the 10th edge, then page 1 ten edges later.
    bus.mode_auto = 1'b1;
    cyc(9);
    chk(K_PAGE, 56'd3, "auto_before_wrap");
    cyc(1);
    chk(K_PAGE, 56'd0, "auto_wrap");
    cyc(9);
    chk(K_PAGE, 56'd0, "auto_before_2nd");
    cyc(1);
    chk(K_PAGE, 56'd1, "auto_2nd");

    // Manual advance with the timer at 5 restarts the 10-cycle interval.
    bus.btn = 1'b1;
    cyc(5);
    chk(K_PAGE, 56'd1, "clr_before");
    cyc(1);
    chk(K_PAGE, 56'd2, "clr_btn_adv");
    cyc(2);
    bus.btn = 1'b0;
    cyc(7);
    chk(K_PAGE, 56'd2, "clr_no_early");
    cyc(1);
    chk(K_PAGE, 56'd3, "clr_auto_adv");

    // Button and timer fire on the same edge: single step 3 -> 0.
    cyc(4);
    bus.btn = 1'b1;
    cyc(5);
    chk(K_PAGE, 56'd3, "coinc_before");
    cyc(1);
    chk(K_PAGE, 56'd0, "coinc_once");
    cyc(2);
    bus.btn = 1'b0;
    bus.mode_auto = 1'b0;
    cyc(8);
    chk(K_PAGE, 56'd0, "coinc_hold");

    // Freeze: new data and a full press are both ignored.
    bus.freeze = 1'b1;
    cyc(1);
    chk(K_FRZ, 56'd1, "frz_flag");
    bus.page_data[31:0] = 32'hDEAD_BEEF;
    bus.btn = 1'b1;
    cyc(8);
    bus.btn = 1'b0;
    cyc(8);
    chk(K_PAGE, 56'd0, "frz_page");
    chk(K_LED, L_ZERO, "frz_led");
    chk(K_FRZ, 56'd1, "frz_flag_hold");
    bus.freeze = 1'b0;
    cyc(1);
    chk(K_LED, L_DEAD, "unfrz_led");
    chk(K_FRZ, 56'd0, "unfrz_flag");
    cyc(3);
    chk(K_PAGE, 56'd0, "unfrz_dropped");

    // Leading-zero blanking against the unblanked instance.
    bus.page_data[31:0] = 32'h0000_0300;
    set_blank_word(32'h0000_0300);
    cyc(1);
    chk(K_LED, L_300, "noblank_300");
    chk(K_BLED, B_300, "blank_300");
    set_blank_word(32'h0000_0000);
    cyc(1);
    chk(K_BLED, B_0, "blank_zero");
    set_blank_word(32'h1000_0000);
    cyc(1);
    chk(K_BLED, B_TOP, "blank_top");

    // Reset mid-debounce discards the partial count.
    press_adv();
    chk(K_PAGE, 56'd1, "pre_rst_page");
    bus.btn = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    chk(K_PAGE, 56'd0, "rst2_page");
    chk(K_LED, L_ZERO, "rst2_led");
    rst = 1'b0;
    cyc(5);
    chk(K_PAGE, 56'd0, "rst2_restart");
    cyc(1);
    chk(K_PAGE, 56'd1, "rst2_adv");
    bus.btn = 1'b0;
    cyc(8);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
